// File: rtl/rc4_prga_decrypt_if.sv
// Bus bundle between the RC4 PRGA engine and its surroundings: control
// handshake, S working-memory port, encrypted ROM port and decrypted RAM port.
interface rc4_prga_decrypt_if #(
    parameter int MSG_AW = 5
);
    logic              start;
    logic              busy;
    logic              done;
    logic              msg_ok;
    logic [7:0]        s_address;
    logic [7:0]        s_wdata;
    logic              s_wren;
    logic [7:0]        s_rdata;
    logic [MSG_AW-1:0] rom_address;
    logic [7:0]        rom_rdata;
    logic [MSG_AW-1:0] ram_address;
    logic [7:0]        ram_wdata;
    logic              ram_wren;

    modport master (
        input  start, s_rdata, rom_rdata,
        output busy, done, msg_ok, s_address, s_wdata, s_wren,
               rom_address, ram_address, ram_wdata, ram_wren
    );

    modport slave (
        output start, s_rdata, rom_rdata,
        input  busy, done, msg_ok, s_address, s_wdata, s_wren,
               rom_address, ram_address, ram_wdata, ram_wren
    );
endinterface

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA engine: walks MSG_LEN bytes, swapping S and XORing the keystream with
// the encrypted ROM into the decrypted RAM, flagging non-lowercase/space output.
module rc4_prga_decrypt #(
    parameter int MSG_LEN      = 32,
    parameter int MSG_AW       = 5,
    parameter int ABORT_ON_BAD = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    rc4_prga_decrypt_if.master   eng
);
    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] INC_I = 4'd1;
    localparam logic [3:0] RD_I  = 4'd2;
    localparam logic [3:0] CAP_I = 4'd3;
    localparam logic [3:0] RD_J  = 4'd4;
    localparam logic [3:0] CAP_J = 4'd5;
    localparam logic [3:0] WR_I  = 4'd6;
    localparam logic [3:0] WR_J  = 4'd7;
    localparam logic [3:0] RD_F  = 4'd8;
    localparam logic [3:0] CAP_F = 4'd9;
    localparam logic [3:0] WR_M  = 4'd10;
    localparam logic [3:0] DONE  = 4'd11;

    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

    logic [3:0]        state_q, state_d;
    logic [7:0]        i_q, i_d, j_q, j_d;
    logic [MSG_AW-1:0] k_q, k_d;
    logic [7:0]        si_q, si_d, sj_q, sj_d, f_q, f_d, enc_q, enc_d;
    logic              msg_ok_q, msg_ok_d;
    logic              arm_q, arm_d;

    logic              accept;
    logic [7:0]        f_addr;
    logic [7:0]        plain;
    logic              byte_ok;

    assign f_addr  = si_q + sj_q;
    assign plain   = f_q ^ enc_q;
    assign byte_ok = (plain == 8'h20) || (plain >= 8'h61 && plain <= 8'h7A);

    // A start still high from the previous accept must drop before it counts again,
    // so a held start yields exactly one run.
    assign accept = ((state_q == IDLE) || (state_q == DONE)) && eng.start && arm_q;

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        si_d     = si_q;
        sj_d     = sj_q;
        f_d      = f_q;
        enc_d    = enc_q;
        msg_ok_d = msg_ok_q;
        arm_d    = accept ? 1'b0 : (!eng.start ? 1'b1 : arm_q);
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    i_d      = '0;
                    j_d      = '0;
                    k_d      = '0;
                    msg_ok_d = 1'b1;
                    state_d  = INC_I;
                end
            end
            INC_I: begin
                i_d     = i_q + 8'd1;
                state_d = RD_I;
            end
            RD_I:  state_d = CAP_I;
            CAP_I: begin
                si_d    = eng.s_rdata;
                j_d     = j_q + eng.s_rdata;
                state_d = RD_J;
            end
            RD_J:  state_d = CAP_J;
            CAP_J: begin
                sj_d    = eng.s_rdata;
                state_d = WR_I;
            end
            WR_I:  state_d = WR_J;
            WR_J:  state_d = RD_F;
            RD_F:  state_d = CAP_F;
            CAP_F: begin
                f_d     = eng.s_rdata;
                enc_d   = eng.rom_rdata;
                state_d = WR_M;
            end
            WR_M: begin
                msg_ok_d = msg_ok_q & byte_ok;
                if (k_q == K_LAST || ((ABORT_ON_BAD != 0) && !byte_ok)) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = INC_I;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            si_q     <= '0;
            sj_q     <= '0;
            f_q      <= '0;
            enc_q    <= '0;
            msg_ok_q <= 1'b1;
            arm_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            si_q     <= si_d;
            sj_q     <= sj_d;
            f_q      <= f_d;
            enc_q    <= enc_d;
            msg_ok_q <= msg_ok_d;
            arm_q    <= arm_d;
        end
    end

    // Memory ports are pure state decodes; everything is 0 outside its own state,
    // which lets the surrounding logic OR several idle engines onto one S port.
    always_comb begin
        eng.s_address   = '0;
        eng.s_wdata     = '0;
        eng.s_wren      = 1'b0;
        eng.rom_address = '0;
        eng.ram_address = '0;
        eng.ram_wdata   = '0;
        eng.ram_wren    = 1'b0;
        case (state_q)
            RD_I: eng.s_address = i_q;
            RD_J: eng.s_address = j_q;
            WR_I: begin
                eng.s_address = i_q;
                eng.s_wdata   = sj_q;
                eng.s_wren    = 1'b1;
            end
            WR_J: begin
                eng.s_address = j_q;
                eng.s_wdata   = si_q;
                eng.s_wren    = 1'b1;
            end
            RD_F: begin
                eng.s_address   = f_addr;
                eng.rom_address = k_q;
            end
            WR_M: begin
                eng.ram_address = k_q;
                eng.ram_wdata   = plain;
                eng.ram_wren    = 1'b1;
            end
            default: ;
        endcase
    end

    assign eng.busy   = (state_q != IDLE) && (state_q != DONE);
    assign eng.done   = (state_q == DONE);
    assign eng.msg_ok = msg_ok_q;
endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench: three engine variants share one S memory, ROM and RAM; results are
// compared against a software RC4 PRGA run on the same starting S.
module tb_rc4_prga_decrypt;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    rc4_prga_decrypt_if #(.MSG_AW(5)) ifa ();
    rc4_prga_decrypt_if #(.MSG_AW(5)) ifb ();
    rc4_prga_decrypt_if #(.MSG_AW(9)) ifc ();

    rc4_prga_decrypt #(.MSG_LEN(32),  .MSG_AW(5), .ABORT_ON_BAD(0)) dut_a (.clk(clk), .reset(reset), .eng(ifa));
    rc4_prga_decrypt #(.MSG_LEN(32),  .MSG_AW(5), .ABORT_ON_BAD(1)) dut_b (.clk(clk), .reset(reset), .eng(ifb));
    rc4_prga_decrypt #(.MSG_LEN(300), .MSG_AW(9), .ABORT_ON_BAD(0)) dut_c (.clk(clk), .reset(reset), .eng(ifc));

    logic [7:0] smem [256];
    logic [7:0] sinit[256];
    logic [7:0] s0   [256];
    logic [7:0] snap [256];
    logic [7:0] exp_s[256];
    logic [7:0] rom    [512];
    logic [7:0] ramm   [512];
    logic [7:0] exp_ram[512];
    logic [7:0] ks     [512];
    logic       load_s, clr_ram;
    logic [7:0] clr_val;
    logic [7:0] s_rd, rom_rd;

    // Idle engines drive all-zero buses, so the shared ports are simple ORs.
    wire [7:0] s_addr   = ifa.s_address | ifb.s_address | ifc.s_address;
    wire [7:0] s_wd     = ifa.s_wdata | ifb.s_wdata | ifc.s_wdata;
    wire       s_we     = ifa.s_wren | ifb.s_wren | ifc.s_wren;
    wire [8:0] rom_addr = {4'b0, ifa.rom_address} | {4'b0, ifb.rom_address} | ifc.rom_address;
    wire [8:0] ram_addr = {4'b0, ifa.ram_address} | {4'b0, ifb.ram_address} | ifc.ram_address;
    wire [7:0] ram_wd   = ifa.ram_wdata | ifb.ram_wdata | ifc.ram_wdata;
    wire       ram_we   = ifa.ram_wren | ifb.ram_wren | ifc.ram_wren;

    assign ifa.s_rdata = s_rd;   assign ifb.s_rdata = s_rd;   assign ifc.s_rdata = s_rd;
    assign ifa.rom_rdata = rom_rd; assign ifb.rom_rdata = rom_rd; assign ifc.rom_rdata = rom_rd;

    always @(posedge clk) begin
        if (load_s) smem <= sinit;
        else if (s_we) smem[s_addr] <= s_wd;
        s_rd   <= smem[s_addr];
        rom_rd <= rom[rom_addr];
        if (clr_ram) begin
            for (int b = 0; b < 512; b++) ramm[b] <= clr_val;
        end else if (ram_we) begin
            ramm[ram_addr] <= ram_wd;
        end
    end

    int total = 0, bad = 0;
    int cyc, sw, rw, nw, mism;
    bit exp_ok;
    string txt = "the quick brown fox jumps over t";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic bit valid_b(input logic [7:0] b);
        return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
    endfunction

    function automatic logic f_done(input int sel);
        case (sel) 0: return ifa.done; 1: return ifb.done; default: return ifc.done; endcase
    endfunction
    function automatic logic f_busy(input int sel);
        case (sel) 0: return ifa.busy; 1: return ifb.busy; default: return ifc.busy; endcase
    endfunction
    function automatic logic f_ok(input int sel);
        case (sel) 0: return ifa.msg_ok; 1: return ifb.msg_ok; default: return ifc.msg_ok; endcase
    endfunction
    task automatic set_start(input int sel, input logic v);
        case (sel) 0: ifa.start = v; 1: ifb.start = v; default: ifc.start = v; endcase
    endtask

    task automatic s_identity();
        for (int x = 0; x < 256; x++) sinit[x] = 8'(x);
        s0 = sinit;
    endtask

    task automatic s_ksa(input logic [23:0] key);
        logic [7:0] j, t, kb;
        for (int x = 0; x < 256; x++) sinit[x] = 8'(x);
        j = 0;
        for (int x = 0; x < 256; x++) begin
            kb = key[16 - 8 * (x % 3) +: 8];
            j = j + sinit[x] + kb;
            t = sinit[x]; sinit[x] = sinit[j]; sinit[j] = t;
        end
        s0 = sinit;
    endtask

    task automatic load_mem(input logic [7:0] fill);
        load_s = 1; clr_ram = 1; clr_val = fill;
        @(posedge clk); #1;
        load_s = 0; clr_ram = 0;
    endtask

    // Reference RC4 PRGA on s0: keystream into ks[], final S into exp_s[].
    task automatic model_ks(input int n);
        logic [7:0] s[256];
        logic [7:0] i, j, t;
        s = s0; i = 0; j = 0;
        for (int b = 0; b < n; b++) begin
            i = i + 1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            ks[b] = s[8'(s[i] + s[j])];
        end
        exp_s = s;
    endtask

    task automatic model_out(input int n, input bit abort, input logic [7:0] fill);
        logic [7:0] p;
        for (int b = 0; b < 512; b++) exp_ram[b] = fill;
        nw = 0; exp_ok = 1;
        for (int b = 0; b < n; b++) begin
            p = ks[b] ^ rom[b];
            exp_ram[b] = p;
            nw++;
            if (!valid_b(p)) exp_ok = 0;
            if (abort && !valid_b(p)) break;
        end
    endtask

    function automatic int ram_mism(input int n);
        int c = 0;
        for (int b = 0; b < n; b++) if (ramm[b] !== exp_ram[b]) c++;
        return c;
    endfunction
    function automatic int s_mism();
        int c = 0;
        for (int x = 0; x < 256; x++) if (smem[x] !== exp_s[x]) c++;
        return c;
    endfunction

    task automatic run(input int sel, input bit hold, input int rst_at, input int snap_at);
        @(negedge clk); set_start(sel, 1'b1);
        @(posedge clk); #1;
        if (!hold) set_start(sel, 1'b0);
        cyc = 0; sw = 0; rw = 0;
        while (!f_done(sel) && cyc < 4000) begin
            if (rst_at != 0 && cyc == rst_at) break;
            sw += int'(s_we); rw += int'(ram_we);
            @(posedge clk); #1;
            cyc++;
            if (cyc == snap_at) snap = smem;
        end
        if (rst_at == 0) chk("run_timeout", 32'(cyc < 4000), 32'd1);
    endtask

    initial begin
        reset = 1; load_s = 0; clr_ram = 0; clr_val = 0;
        ifa.start = 0; ifb.start = 0; ifc.start = 0;
        for (int b = 0; b < 512; b++) rom[b] = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        chk("rst_busy",   32'(ifa.busy),   32'd0);
        chk("rst_done",   32'(ifa.done),   32'd0);
        chk("rst_msg_ok", 32'(ifa.msg_ok), 32'd1);
        chk("rst_bus",    32'(s_addr | s_wd | ram_wd | ram_addr | 9'(s_we) | 9'(ram_we)), 32'd0);

        // 1: identity S, zero ROM, no abort
        s_identity(); load_mem(8'h00);
        model_ks(32); model_out(32, 0, 8'h00);
        run(0, 0, 0, 20);
        chk("t1_ram0",  32'(ramm[0]), 32'h02);
        chk("t1_ram1",  32'(ramm[1]), 32'h05);
        chk("t1_ram",   32'(ram_mism(32)), 32'd0);
        chk("t1_s2",    32'(snap[2]), 32'd3);
        chk("t1_s3",    32'(snap[3]), 32'd2);
        chk("t1_sfin",  32'(s_mism()), 32'd0);
        chk("t1_cyc",   32'(cyc), 32'd320);
        chk("t1_ok",    32'(ifa.msg_ok), 32'd0);
        chk("t1_busy",  32'(ifa.busy), 32'd0);

        // 2: KSA(000249) with ROM encrypting plain text
        s_ksa(24'h000249); load_mem(8'h00);
        model_ks(32);
        for (int b = 0; b < 32; b++) rom[b] = ks[b] ^ 8'(txt[b]);
        run(0, 0, 0, 0);
        for (int b = 0; b < 32; b++) exp_ram[b] = 8'(txt[b]);
        chk("t2_text", 32'(ram_mism(32)), 32'd0);
        chk("t2_ok",   32'(ifa.msg_ok), 32'd1);
        chk("t2_cyc",  32'(cyc), 32'd320);
        chk("t2_swr",  32'(sw), 32'd64);
        chk("t2_rwr",  32'(rw), 32'd32);

        // 3: abort on byte 5 = 'A'
        s_ksa({8'($urandom), 8'($urandom), 8'($urandom)}); load_mem(8'hEE);
        model_ks(32);
        for (int b = 0; b < 32; b++) rom[b] = 8'($urandom);
        for (int b = 0; b < 5; b++) rom[b] = ks[b] ^ (8'h61 + 8'(b));
        rom[5] = ks[5] ^ 8'h41;
        model_out(32, 1, 8'hEE);
        run(1, 0, 0, 0);
        chk("t3_ram5", 32'(ramm[5]), 32'h41);
        chk("t3_ram",  32'(ram_mism(32)), 32'd0);
        chk("t3_cyc",  32'(cyc), 32'd60);
        chk("t3_ok",   32'(ifb.msg_ok), 32'd0);
        chk("t3_rwr",  32'(rw), 32'd6);

        // 4: reset during WR_I of the third byte, then a clean rerun
        s_ksa(24'h1A2B3C); load_mem(8'h00);
        for (int b = 0; b < 32; b++) rom[b] = 8'($urandom);
        run(0, 0, 25, 0);
        reset = 1; @(posedge clk); #1; reset = 0;
        chk("t4_busy", 32'(ifa.busy), 32'd0);
        chk("t4_done", 32'(ifa.done), 32'd0);
        chk("t4_ok",   32'(ifa.msg_ok), 32'd1);
        chk("t4_bus",  32'(s_addr | s_wd | ram_wd | ram_addr | 9'(s_we) | 9'(ram_we)), 32'd0);
        sw = 0;
        repeat (5) begin sw += int'(s_we) + int'(ram_we); @(posedge clk); #1; end
        chk("t4_nowr", 32'(sw), 32'd0);
        load_mem(8'h00);
        model_ks(32); model_out(32, 0, 8'h00);
        run(0, 0, 0, 0);
        chk("t4_ram",  32'(ram_mism(32)), 32'd0);
        chk("t4_s",    32'(s_mism()), 32'd0);
        chk("t4_ok2",  32'(ifa.msg_ok), 32'(exp_ok));

        // 5: 300-byte message, i wraps
        s_identity(); load_mem(8'h00);
        for (int b = 0; b < 300; b++) rom[b] = 8'($urandom);
        model_ks(300); model_out(300, 0, 8'h00);
        run(2, 0, 0, 0);
        chk("t5_ram", 32'(ram_mism(300)), 32'd0);
        chk("t5_s",   32'(s_mism()), 32'd0);
        chk("t5_cyc", 32'(cyc), 32'd3000);
        chk("t5_ok",  32'(ifc.msg_ok), 32'(exp_ok));

        // 6: start held through the run gives one run only
        s_identity(); load_mem(8'h00);
        run(0, 1, 0, 0);
        chk("t6_cyc", 32'(cyc), 32'd320);
        sw = 0;
        repeat (30) begin sw += int'(f_busy(0)); @(posedge clk); #1; end
        chk("t6_nobusy", 32'(sw), 32'd0);
        chk("t6_done",   32'(ifa.done), 32'd1);
        ifa.start = 0; @(posedge clk); #1;
        ifa.start = 1; @(posedge clk); #1;
        ifa.start = 0;
        chk("t6_restart", 32'(ifa.busy), 32'd1);
        cyc = 0;
        while (!ifa.done && cyc < 4000) begin @(posedge clk); #1; cyc++; end
        chk("t6_done2", 32'(ifa.done), 32'd1);

        // 7: random key / random ROM on both 32-byte variants
        for (int r = 0; r < 2; r++) begin
            s_ksa({8'($urandom), 8'($urandom), 8'($urandom)}); load_mem(8'h5A);
            for (int b = 0; b < 32; b++) rom[b] = (r == 1 && b < 10) ? ks[b] : 8'($urandom);
            model_ks(32);
            if (r == 1) for (int b = 0; b < 10; b++) rom[b] = ks[b] ^ 8'($urandom_range(8'h61, 8'h7A));
            model_out(32, r == 1, 8'h5A);
            run(r, 0, 0, 0);
            chk("t7_ram", 32'(ram_mism(32)), 32'd0);
            chk("t7_cyc", 32'(cyc), 32'(10 * nw));
            chk("t7_ok",  32'(f_ok(r)), 32'(exp_ok));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
